// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard unit and the pipeline stages
// that consume its stall, flush and forwarding controls.
package hazard_pkg;

  // Default widths for the register index and the performance counters
  localparam int DEFAULT_REG_W = 5;
  localparam int DEFAULT_CNT_W = 16;

  // ResultSrc encoding that marks a load in the decoder
  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // Operand mux select for the E-stage ALU inputs
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } forward_sel_e;

  // The single reason the pipeline is being held or redirected this cycle
  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'b00,
    CAUSE_MEM    = 2'b01,
    CAUSE_BRANCH = 2'b10,
    CAUSE_LOAD   = 2'b11
  } hazard_cause_e;

  // M holds the younger result, so a hit there beats a hit in W
  function automatic forward_sel_e pickForward(input logic hitM, input logic hitW);
    forward_sel_e sel;
    sel = FWD_RF;
    if (hitM) begin
      sel = FWD_M;
    end else if (hitW) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle between the hazard unit and the pipeline: decoder fields and
// resolution inputs going in, stage-register controls and counters coming out.
interface hazard_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);

  logic [REG_W-1:0] Rs1D;
  logic [REG_W-1:0] Rs2D;
  logic [REG_W-1:0] RdD;
  logic             RegWriteD;
  logic [1:0]       ResultSrcD;
  logic             PCSrcE;
  logic             MemReqM;
  logic             MemReadyM;

  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;

  logic [CNT_W-1:0] LoadStallCnt;
  logic [CNT_W-1:0] FlushCnt;
  logic [CNT_W-1:0] MemStallCnt;

  // Hazard unit side: sees decoder and resolution fields, drives controls
  modport master (
    input  Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE,
    output LoadStallCnt, FlushCnt, MemStallCnt
  );

  // Pipeline side: supplies decoder and resolution fields, obeys controls
  modport slave (
    output Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE,
    input  LoadStallCnt, FlushCnt, MemStallCnt
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping, so a long run
// can never make a busy counter look idle.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count one per flagged cycle until every bit is set, then hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage core. It keeps a shadow copy of the destination
// registers sitting in E, M and W, advancing that copy with the same stall and
// flush decisions it hands to the real stage registers, so only decoder fields
// and the E/M resolution signals are needed from the datapath.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = DEFAULT_REG_W,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  hazard_unit_if.master hif
);

  logic [REG_W-1:0] rs1E;
  logic [REG_W-1:0] rs2E;
  logic [REG_W-1:0] rdE;
  logic             regWriteE;
  logic             loadE;

  logic [REG_W-1:0] rdM;
  logic             regWriteM;

  logic [REG_W-1:0] rdW;
  logic             regWriteW;

  logic             memStall;
  logic             lwStall;
  hazard_cause_e    cause;

  logic             stallF;
  logic             stallD;
  logic             stallE;
  logic             stallM;
  logic             flushD;
  logic             flushE;
  logic             flushW;

  forward_sel_e     forwardA;
  forward_sel_e     forwardB;

  logic             loadStallInc;
  logic             flushInc;
  logic             memStallInc;
  logic [CNT_W-1:0] loadStallCount;
  logic [CNT_W-1:0] flushCount;
  logic [CNT_W-1:0] memStallCount;

  // Raw hazard conditions; a load into x0 can never create a dependency
  assign memStall = hif.MemReqM & ~hif.MemReadyM;
  assign lwStall  = loadE & regWriteE & (rdE != '0) &
                    ((rdE == hif.Rs1D) | (rdE == hif.Rs2D));

  // Pick one cause per cycle; held at none during reset so outputs drop at once
  always_comb begin
    cause = CAUSE_NONE;
    if (!reset) begin
      cause = CAUSE_NONE;
    end else if (memStall) begin
      cause = CAUSE_MEM;
    end else if (hif.PCSrcE) begin
      cause = CAUSE_BRANCH;
    end else if (lwStall) begin
      cause = CAUSE_LOAD;
    end
  end

  // Turn the selected cause into stage-register stall and flush lines
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    case (cause)
      CAUSE_MEM: begin
        // Freeze F..M and drain W; a pending redirect waits because E is frozen
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end
      CAUSE_BRANCH: begin
        flushD = 1'b1;
        flushE = 1'b1;
      end
      CAUSE_LOAD: begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Operand forwarding from the shadow M and W destinations, skipping x0
  always_comb begin
    forwardA = pickForward(regWriteM && (rdM != '0) && (rdM == rs1E),
                           regWriteW && (rdW != '0) && (rdW == rs1E));
    forwardB = pickForward(regWriteM && (rdM != '0) && (rdM == rs2E),
                           regWriteW && (rdW != '0) && (rdW == rs2E));
  end

  // Shadow E slot: hold on stall, bubble on flush, otherwise capture decode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs1E      <= '0;
      rs2E      <= '0;
      rdE       <= '0;
      regWriteE <= 1'b0;
      loadE     <= 1'b0;
    end else if (!stallE) begin
      if (flushE) begin
        rs1E      <= '0;
        rs2E      <= '0;
        rdE       <= '0;
        regWriteE <= 1'b0;
        loadE     <= 1'b0;
      end else begin
        rs1E      <= hif.Rs1D;
        rs2E      <= hif.Rs2D;
        rdE       <= hif.RdD;
        regWriteE <= hif.RegWriteD;
        loadE     <= (hif.ResultSrcD == RESULT_LOAD);
      end
    end
  end

  // Shadow M slot: hold while memory is busy, otherwise follow E
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdM       <= '0;
      regWriteM <= 1'b0;
    end else if (!stallM) begin
      rdM       <= rdE;
      regWriteM <= regWriteE;
    end
  end

  // Shadow W slot: bubble while memory is busy, otherwise follow M
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdW       <= '0;
      regWriteW <= 1'b0;
    end else if (flushW) begin
      rdW       <= '0;
      regWriteW <= 1'b0;
    end else begin
      rdW       <= rdM;
      regWriteW <= regWriteM;
    end
  end

  assign loadStallInc = (cause == CAUSE_LOAD);
  assign flushInc     = (cause == CAUSE_BRANCH);
  assign memStallInc  = (cause == CAUSE_MEM);

  sat_counter #(.CNT_W(CNT_W)) loadStallCounter (
    .clk   (clk),
    .reset (reset),
    .inc   (loadStallInc),
    .count (loadStallCount)
  );

  sat_counter #(.CNT_W(CNT_W)) flushCounter (
    .clk   (clk),
    .reset (reset),
    .inc   (flushInc),
    .count (flushCount)
  );

  sat_counter #(.CNT_W(CNT_W)) memStallCounter (
    .clk   (clk),
    .reset (reset),
    .inc   (memStallInc),
    .count (memStallCount)
  );

  assign hif.StallF       = stallF;
  assign hif.StallD       = stallD;
  assign hif.StallE       = stallE;
  assign hif.StallM       = stallM;
  assign hif.FlushD       = flushD;
  assign hif.FlushE       = flushE;
  assign hif.FlushW       = flushW;
  assign hif.ForwardAE    = forwardA;
  assign hif.ForwardBE    = forwardB;
  assign hif.LoadStallCnt = loadStallCount;
  assign hif.FlushCnt     = flushCount;
  assign hif.MemStallCnt  = memStallCount;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed instruction sequences drive a full-width
// instance and a 2-bit-counter instance in lockstep; a stage-level model of
// the E/M/W contents predicts every control output on every cycle.
module tb_hazard_unit;
  import hazard_pkg::*;

  typedef struct {
    int rs1;
    int rs2;
    int rd;
    bit we;
    bit load;
  } slot_t;

  typedef struct {
    int stallF;
    int stallD;
    int stallE;
    int stallM;
    int flushD;
    int flushE;
    int flushW;
    int fwdA;
    int fwdB;
    int cause;
  } expect_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1D;
  logic [4:0] rs2D;
  logic [4:0] rdD;
  logic       regWriteD;
  logic [1:0] resultSrcD;
  logic       pcSrcE;
  logic       memReqM;
  logic       memReadyM;

  int compareCount = 0;
  int mismatchCount = 0;

  slot_t slotE;
  slot_t slotM;
  slot_t slotW;
  int loadEvents = 0;
  int branchEvents = 0;
  int memEvents = 0;

  hazard_unit_if #(.REG_W(5), .CNT_W(16)) hif ();
  hazard_unit_if #(.REG_W(5), .CNT_W(2))  sif ();

  assign hif.Rs1D = rs1D;
  assign hif.Rs2D = rs2D;
  assign hif.RdD = rdD;
  assign hif.RegWriteD = regWriteD;
  assign hif.ResultSrcD = resultSrcD;
  assign hif.PCSrcE = pcSrcE;
  assign hif.MemReqM = memReqM;
  assign hif.MemReadyM = memReadyM;

  assign sif.Rs1D = rs1D;
  assign sif.Rs2D = rs2D;
  assign sif.RdD = rdD;
  assign sif.RegWriteD = regWriteD;
  assign sif.ResultSrcD = resultSrcD;
  assign sif.PCSrcE = pcSrcE;
  assign sif.MemReqM = memReqM;
  assign sif.MemReadyM = memReadyM;

  hazard_unit #(.REG_W(5), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif)
  );

  hazard_unit #(.REG_W(5), .CNT_W(2)) dutSmall (
    .clk   (clk),
    .reset (reset),
    .hif   (sif)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  function automatic slot_t emptySlot();
    slot_t s;
    s.rs1 = 0;
    s.rs2 = 0;
    s.rd = 0;
    s.we = 1'b0;
    s.load = 1'b0;
    return s;
  endfunction

  function automatic int satCount(input int events, input int width);
    int top;
    top = (1 << width) - 1;
    return (events > top) ? top : events;
  endfunction

  // Where an E-stage operand must come from: newest real writer wins
  function automatic int forwardFor(input int src);
    if (slotM.we && slotM.rd != 0 && slotM.rd == src) return 2;
    if (slotW.we && slotW.rd != 0 && slotW.rd == src) return 1;
    return 0;
  endfunction

  // What the unit must present this cycle, from pipeline contents and pins
  function automatic expect_t modelOutputs();
    expect_t e;
    bit waitMem;
    bit loadUse;
    e = '{default: 0};
    if (reset !== 1'b1) return e;
    e.fwdA = forwardFor(slotE.rs1);
    e.fwdB = forwardFor(slotE.rs2);
    waitMem = memReqM && !memReadyM;
    loadUse = slotE.load && slotE.we && slotE.rd != 0 &&
              (slotE.rd == int'(rs1D) || slotE.rd == int'(rs2D));
    if (waitMem) begin
      e.cause = 1;
      e.stallF = 1; e.stallD = 1; e.stallE = 1; e.stallM = 1; e.flushW = 1;
    end else if (pcSrcE) begin
      e.cause = 2;
      e.flushD = 1; e.flushE = 1;
    end else if (loadUse) begin
      e.cause = 3;
      e.stallF = 1; e.stallD = 1; e.flushE = 1;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int rs1, input int rs2, input int rd, input bit we,
                               input int rsrc, input bit pc, input bit mreq, input bit mrdy);
    @(posedge clk);
    #1;
    rs1D = 5'(rs1);
    rs2D = 5'(rs2);
    rdD = 5'(rd);
    regWriteD = we;
    resultSrcD = 2'(rsrc);
    pcSrcE = pc;
    memReqM = mreq;
    memReadyM = mrdy;
    @(negedge clk);
    #1;
  endtask

  task automatic applyIdle();
    applyStimulus(0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  // Model reset follows the DUT reset asynchronously
  always @(negedge reset) begin
    slotE = emptySlot();
    slotM = emptySlot();
    slotW = emptySlot();
    loadEvents = 0;
    branchEvents = 0;
    memEvents = 0;
  end

  // Advance the model one instruction slot per clock
  always @(posedge clk) begin
    expect_t e;
    if (reset === 1'b1) begin
      e = modelOutputs();
      if (e.cause == 1) memEvents++;
      if (e.cause == 2) branchEvents++;
      if (e.cause == 3) loadEvents++;
      if (e.flushW != 0) begin
        slotW = emptySlot();
      end else begin
        slotW = emptySlot();
        slotW.rd = slotM.rd;
        slotW.we = slotM.we;
      end
      if (e.stallM == 0) begin
        slotM = emptySlot();
        slotM.rd = slotE.rd;
        slotM.we = slotE.we;
      end
      if (e.stallE == 0) begin
        if (e.flushE != 0) begin
          slotE = emptySlot();
        end else begin
          slotE.rs1 = int'(rs1D);
          slotE.rs2 = int'(rs2D);
          slotE.rd = int'(rdD);
          slotE.we = regWriteD;
          slotE.load = (resultSrcD == 2'b01);
        end
      end
    end
  end

  // Every cycle, compare both instances against the model mid-cycle
  always @(negedge clk) begin
    expect_t e;
    e = modelOutputs();
    checkOutput("StallF", hif.StallF, e.stallF);
    checkOutput("StallD", hif.StallD, e.stallD);
    checkOutput("StallE", hif.StallE, e.stallE);
    checkOutput("StallM", hif.StallM, e.stallM);
    checkOutput("FlushD", hif.FlushD, e.flushD);
    checkOutput("FlushE", hif.FlushE, e.flushE);
    checkOutput("FlushW", hif.FlushW, e.flushW);
    checkOutput("ForwardAE", hif.ForwardAE, e.fwdA);
    checkOutput("ForwardBE", hif.ForwardBE, e.fwdB);
    checkOutput("LoadStallCnt", hif.LoadStallCnt, satCount(loadEvents, 16));
    checkOutput("FlushCnt", hif.FlushCnt, satCount(branchEvents, 16));
    checkOutput("MemStallCnt", hif.MemStallCnt, satCount(memEvents, 16));
    checkOutput("small.StallF", sif.StallF, e.stallF);
    checkOutput("small.FlushE", sif.FlushE, e.flushE);
    checkOutput("small.ForwardBE", sif.ForwardBE, e.fwdB);
    checkOutput("small.LoadStallCnt", sif.LoadStallCnt, satCount(loadEvents, 2));
    checkOutput("small.FlushCnt", sif.FlushCnt, satCount(branchEvents, 2));
    checkOutput("small.MemStallCnt", sif.MemStallCnt, satCount(memEvents, 2));
  end

  // Hard stop in case the sequence never completes
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequences with hand-computed spot checks
  initial begin
    slotE = emptySlot();
    slotM = emptySlot();
    slotW = emptySlot();
    reset = 1'b0;
    rs1D = '0; rs2D = '0; rdD = '0; regWriteD = 1'b0; resultSrcD = '0;
    pcSrcE = 1'b0; memReqM = 1'b0; memReadyM = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("dir.reset.StallF", hif.StallF, 0);
    checkOutput("dir.reset.LoadStallCnt", hif.LoadStallCnt, 0);

    $display("[TB] load-use");
    applyStimulus(0, 0, 5, 1'b1, 1, 1'b0, 1'b0, 1'b1);
    checkOutput("dir.lu.noStall", hif.StallF, 0);
    applyStimulus(5, 0, 6, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    checkOutput("dir.lu.StallF", hif.StallF, 1);
    checkOutput("dir.lu.StallD", hif.StallD, 1);
    checkOutput("dir.lu.FlushE", hif.FlushE, 1);
    checkOutput("dir.lu.FlushD", hif.FlushD, 0);
    applyStimulus(5, 0, 6, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    checkOutput("dir.lu.released", hif.StallF, 0);
    checkOutput("dir.lu.LoadStallCnt", hif.LoadStallCnt, 1);
    applyIdle();
    checkOutput("dir.lu.ForwardAE", hif.ForwardAE, 1);
    applyIdle();
    applyIdle();

    $display("[TB] forwarding");
    applyStimulus(0, 0, 7, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 7, 8, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    checkOutput("dir.fw.noStall", hif.StallF, 0);
    applyStimulus(0, 7, 9, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    checkOutput("dir.fw.fromM", hif.ForwardBE, 2);
    applyIdle();
    checkOutput("dir.fw.fromW", hif.ForwardBE, 1);
    applyStimulus(0, 0, 0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    applyIdle();
    checkOutput("dir.fw.x0", hif.ForwardBE, 0);
    applyStimulus(0, 0, 0, 1'b1, 1, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 0, 3, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    checkOutput("dir.fw.x0LoadNoStall", hif.StallF, 0);

    $display("[TB] taken branch over load-use");
    applyIdle();
    applyStimulus(0, 0, 3, 1'b1, 1, 1'b0, 1'b0, 1'b1);
    applyStimulus(3, 0, 4, 1'b1, 0, 1'b1, 1'b0, 1'b1);
    checkOutput("dir.br.FlushD", hif.FlushD, 1);
    checkOutput("dir.br.FlushE", hif.FlushE, 1);
    checkOutput("dir.br.StallF", hif.StallF, 0);
    checkOutput("dir.br.StallD", hif.StallD, 0);
    applyIdle();
    checkOutput("dir.br.FlushCnt", hif.FlushCnt, 1);
    checkOutput("dir.br.LoadStallCnt", hif.LoadStallCnt, 1);

    $display("[TB] memory wait with pending redirect");
    applyStimulus(0, 0, 10, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(10, 0, 11, 1'b1, 0, 1'b1, 1'b1, 1'b0);
      checkOutput("dir.mem.StallF", hif.StallF, 1);
      checkOutput("dir.mem.StallM", hif.StallM, 1);
      checkOutput("dir.mem.FlushW", hif.FlushW, 1);
      checkOutput("dir.mem.FlushE", hif.FlushE, 0);
      checkOutput("dir.mem.FlushD", hif.FlushD, 0);
    end
    applyStimulus(10, 0, 11, 1'b1, 0, 1'b1, 1'b1, 1'b1);
    checkOutput("dir.mem.readyFlushD", hif.FlushD, 1);
    checkOutput("dir.mem.readyFlushE", hif.FlushE, 1);
    checkOutput("dir.mem.readyStallE", hif.StallE, 0);
    checkOutput("dir.mem.MemStallCnt", hif.MemStallCnt, 3);
    applyIdle();
    checkOutput("dir.mem.FlushCnt", hif.FlushCnt, 2);

    $display("[TB] counter saturation");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 4, 1'b1, 1, 1'b0, 1'b0, 1'b1);
      applyStimulus(0, 4, 12, 1'b1, 0, 1'b0, 1'b0, 1'b1);
      applyStimulus(0, 4, 12, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    end
    applyIdle();
    checkOutput("dir.sat.wide", hif.LoadStallCnt, 5);
    checkOutput("dir.sat.narrow", sif.LoadStallCnt, 3);

    $display("[TB] async reset mid memory stall");
    applyStimulus(0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkOutput("dir.rst.before", hif.StallF, 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("dir.rst.StallF", hif.StallF, 0);
    checkOutput("dir.rst.StallM", hif.StallM, 0);
    checkOutput("dir.rst.FlushW", hif.FlushW, 0);
    checkOutput("dir.rst.MemStallCnt", hif.MemStallCnt, 0);
    checkOutput("dir.rst.LoadStallCnt", hif.LoadStallCnt, 0);
    memReqM = 1'b0;
    memReadyM = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    applyIdle();
    checkOutput("dir.rst.afterStallF", hif.StallF, 0);
    checkOutput("dir.rst.afterFlushE", hif.FlushE, 0);
    applyIdle();
    checkOutput("dir.rst.afterCnt", hif.FlushCnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
